// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if
//   Groups the timer control unit's register/event inputs and its status
//   outputs into one bundle.
//   master modport : stimulus side (drives tick, writes, start/stop, irq_ack)
//   slave modport  : timer_ctrl side (drives ps, edge_mode, count, running,
//                    done, irq and the debug state/pend observation signals)
//   Handshake: there is no backpressure. Every input is a single-cycle
//   strobe qualified only by itself (wr_en, start, stop, tick, irq_ack),
//   sampled on the rising clock edge, and always accepted or deliberately
//   ignored according to the current state.
interface timer_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             tick;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             stop;
  logic             irq_ack;

  logic [2:0]       ps;
  logic             edge_mode;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic             irq;

  // Observation of the FSM state and pending bits.
  logic [1:0]       dbg_state;
  logic             dbg_tc_pend;
  logic             dbg_cmp_pend;

  modport master (
    output tick, wr_en, wr_addr, wr_data, start, stop, irq_ack,
    input  ps, edge_mode, count, running, done, irq,
    input  dbg_state, dbg_tc_pend, dbg_cmp_pend
  );

  modport slave (
    input  tick, wr_en, wr_addr, wr_data, start, stop, irq_ack,
    output ps, edge_mode, count, running, done, irq,
    output dbg_state, dbg_tc_pend, dbg_cmp_pend
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Control unit for a down-counting timer. Sequences IDLE/RUN/PAUSE,
//   decrements on each prescaler tick while running, reloads in periodic
//   mode, and raises a one-cycle done pulse plus a held level interrupt on
//   each terminal event.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : timer_ctrl_if.slave (tick, register writes, start/stop, irq_ack
//         in; ps, edge_mode, count, running, done, irq and debug out)
// Optional feature macro: TIMER_CTRL_CMP_EN
//   defined   -> COMPARE register and compare interrupt exist
//   undefined -> COMPARE writes ignored, cmp_pend tied to 0
// Register map: 0 CTRL, 1 RELOAD, 2 COMPARE, 3 COUNT.
// CTRL: [0] periodic, [3:1] ps, [4] edge_mode, [5] irq_en, [6] cmp_irq_en.
module timer_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  timer_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_RELOAD  = 2'd1;
  localparam logic [1:0] A_COMPARE = 2'd2;
  localparam logic [1:0] A_COUNT   = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_done;
  logic             r_irq;
  logic             r_periodic;
  logic [2:0]       r_ps;
  logic             r_edge;
  logic             r_irq_en;
  logic             r_tc_pend;

  logic             w_ctrl_wr;
  logic             w_reload_wr;
  logic             w_compare_wr;
  logic             w_count_wr;
  logic [WIDTH-1:0] w_dec;
  logic [1:0]       w_state_nx;
  logic [WIDTH-1:0] w_count_nx;
  logic             w_tc_set;
  logic             w_cmp_set;
  logic             w_cmp_hit;
  logic             w_tc_pend_nx;
  logic             w_cmp_pend_nx;
  logic             w_irq_en_nx;
  logic             w_cmp_irq_en_nx;
  logic             w_irq_nx;

  assign w_ctrl_wr    = bus.wr_en && (bus.wr_addr == A_CTRL);
  assign w_reload_wr  = bus.wr_en && (bus.wr_addr == A_RELOAD);
  assign w_compare_wr = bus.wr_en && (bus.wr_addr == A_COMPARE);
  assign w_count_wr   = bus.wr_en && (bus.wr_addr == A_COUNT);
  assign w_dec        = r_count - 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_tc_set   = 1'b0;
    w_cmp_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stop outranks start; a tick alongside start is dropped because
        // count is loaded from RELOAD instead.
        if (bus.stop) begin
          w_state_nx = S_IDLE;
        end else if (bus.start) begin
          w_state_nx = S_RUN;
          w_count_nx = r_reload;
        end else if (w_count_wr) begin
          w_count_nx = bus.wr_data;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_nx = S_PAUSE;
        end else if (bus.tick) begin
          if (r_count != '0) begin
            w_count_nx = w_dec;
            w_cmp_set  = w_cmp_hit;
          end else begin
            w_tc_set = 1'b1;
            if (r_periodic) begin
              w_count_nx = r_reload;
            end else begin
              w_state_nx = S_IDLE;
            end
          end
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_state_nx = S_IDLE;
        end else if (bus.start) begin
          w_state_nx = S_RUN;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // A new event in the same cycle as irq_ack keeps its pend bit set.
  assign w_tc_pend_nx = w_tc_set | (r_tc_pend & ~bus.irq_ack);
  assign w_irq_en_nx  = w_ctrl_wr ? bus.wr_data[5] : r_irq_en;
  // irq is registered from the next-state pend/enable values so it rises
  // in the same cycle as done.
  assign w_irq_nx = (w_tc_pend_nx & w_irq_en_nx) |
                    (w_cmp_pend_nx & w_cmp_irq_en_nx);

`ifdef TIMER_CTRL_CMP_EN
  logic [WIDTH-1:0] r_compare;
  logic             r_cmp_irq_en;
  logic             r_cmp_pend;

  assign w_cmp_hit       = (w_dec == r_compare);
  assign w_cmp_pend_nx   = w_cmp_set | (r_cmp_pend & ~bus.irq_ack);
  assign w_cmp_irq_en_nx = w_ctrl_wr ? bus.wr_data[6] : r_cmp_irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_compare    <= '1;
      r_cmp_irq_en <= 1'b0;
      r_cmp_pend   <= 1'b0;
    end else begin
      r_cmp_pend <= w_cmp_pend_nx;
      if (w_compare_wr) r_compare <= bus.wr_data;
      if (w_ctrl_wr) r_cmp_irq_en <= bus.wr_data[6];
    end
  end

  assign bus.dbg_cmp_pend = r_cmp_pend;
`else
  logic w_unused_cmp;

  assign w_cmp_hit       = 1'b0;
  assign w_cmp_pend_nx   = 1'b0;
  assign w_cmp_irq_en_nx = 1'b0;
  assign w_unused_cmp    = ^{w_cmp_set, w_compare_wr, bus.wr_data[6]};

  assign bus.dbg_cmp_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_irq      <= 1'b0;
      r_periodic <= 1'b0;
      r_ps       <= 3'd0;
      r_edge     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_tc_pend  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_running <= (w_state_nx == S_RUN);
      r_done    <= w_tc_set;
      r_tc_pend <= w_tc_pend_nx;
      r_irq     <= w_irq_nx;
      if (w_reload_wr) r_reload <= bus.wr_data;
      if (w_ctrl_wr) begin
        r_periodic <= bus.wr_data[0];
        r_irq_en   <= bus.wr_data[5];
        // Prescaler configuration is frozen outside IDLE so the input path
        // is never reconfigured mid-count.
        if (r_state == S_IDLE) begin
          r_ps   <= bus.wr_data[3:1];
          r_edge <= bus.wr_data[4];
        end
      end
    end
  end

  logic w_unused_data;
  assign w_unused_data = ^bus.wr_data[WIDTH-1:7];

  assign bus.ps          = r_ps;
  assign bus.edge_mode   = r_edge;
  assign bus.count       = r_count;
  assign bus.running     = r_running;
  assign bus.done        = r_done;
  assign bus.irq         = r_irq;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_tc_pend = r_tc_pend;
endmodule
